// File: rtl/io_pkg.sv
// Shared types and constants for the UART transmit byte queue.
package io_pkg;

   typedef enum logic [1:0] {
      Q_IDLE      = 2'd0,
      Q_WAIT_BUSY = 2'd1,
      Q_WAIT_DONE = 2'd2
   } TX_QUEUE_STATE;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/io_byte_fifo_mem.sv
// Byte storage for the transmit queue: synchronous write, asynchronous read.
module io_byte_fifo_mem #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
) (
   input  logic                       clk,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic [$clog2(DEPTH)-1:0]   rd_addr,
   output logic [DATA_W-1:0]          rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/io_tx_byte_queue.sv
// Byte FIFO feeding the UART output controller over a value/trigger/ready handshake.
// Define IO_TX_BYTE_QUEUE_CRLF_EN to expand each LF into a CR, LF pair on the way out.
module io_tx_byte_queue
   import io_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_valid,
   input  logic [DATA_W-1:0]          wr_data,
   output logic                       wr_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   input  logic                       overflow_clr,
   output logic [DATA_W-1:0]          io_output_value,
   output logic                       io_output_trigger,
   input  logic                       io_output_ready_trigger
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic              overflow_q, overflow_d;
   logic              trig_q, trig_d;
   logic [DATA_W-1:0] value_q, value_d;
   TX_QUEUE_STATE     state_q, state_d;
   logic [DATA_W-1:0] head_data;
   logic              wr_fire;
   logic              pop;
`ifdef IO_TX_BYTE_QUEUE_CRLF_EN
   logic              crlf_pending_q, crlf_pending_d;
`endif

   // Full is judged on the registered level, so a same-cycle pop never frees a slot.
   assign wr_ready = (level_q != FULL_LEVEL);
   assign wr_fire  = wr_valid && wr_ready;

   io_byte_fifo_mem #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_fire),
      .wr_addr (wr_ptr_q),
      .wr_data (wr_data),
      .rd_addr (rd_ptr_q),
      .rd_data (head_data)
   );

   always_comb begin
      state_d    = state_q;
      trig_d     = 1'b0;
      value_d    = value_q;
      pop        = 1'b0;
`ifdef IO_TX_BYTE_QUEUE_CRLF_EN
      crlf_pending_d = crlf_pending_q;
`endif
      case (state_q)
         Q_IDLE: begin
            if ((level_q != '0) && io_output_ready_trigger) begin
               trig_d  = 1'b1;
               state_d = Q_WAIT_BUSY;
`ifdef IO_TX_BYTE_QUEUE_CRLF_EN
               if ((head_data == DATA_W'(ASCII_LF)) && !crlf_pending_q) begin
                  value_d        = DATA_W'(ASCII_CR);
                  crlf_pending_d = 1'b1;
               end else begin
                  value_d        = head_data;
                  pop            = 1'b1;
                  crlf_pending_d = 1'b0;
               end
`else
               value_d = head_data;
               pop     = 1'b1;
`endif
            end
         end
         // Ready is still high the cycle after a trigger; wait for it to drop first.
         Q_WAIT_BUSY: begin
            if (!io_output_ready_trigger) begin
               state_d = Q_WAIT_DONE;
            end
         end
         Q_WAIT_DONE: begin
            if (io_output_ready_trigger) begin
               state_d = Q_IDLE;
            end
         end
         default: state_d = Q_IDLE;
      endcase

      wr_ptr_d = wr_fire ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

      case ({wr_fire, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      if (overflow_clr) begin
         overflow_d = 1'b0;
      end else if (wr_valid && !wr_ready) begin
         overflow_d = 1'b1;
      end else begin
         overflow_d = overflow_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         trig_q     <= 1'b0;
         value_q    <= '0;
         state_q    <= Q_IDLE;
`ifdef IO_TX_BYTE_QUEUE_CRLF_EN
         crlf_pending_q <= 1'b0;
`endif
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         trig_q     <= trig_d;
         value_q    <= value_d;
         state_q    <= state_d;
`ifdef IO_TX_BYTE_QUEUE_CRLF_EN
         crlf_pending_q <= crlf_pending_d;
`endif
      end
   end

   assign level             = level_q;
   assign overflow          = overflow_q;
   assign io_output_trigger = trig_q;
   assign io_output_value   = value_q;

endmodule

// File: tb/tb_io_tx_byte_queue.sv
// Directed bench for io_tx_byte_queue with a UART controller model and an issue scoreboard.
module tb_io_tx_byte_queue;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_ready;
   logic [4:0] level;
   logic       overflow;
   logic       overflow_clr = 1'b0;
   logic [7:0] io_output_value;
   logic       io_output_trigger;
   logic       io_ready;

   logic       auto_ready = 1'b1;
   logic       auto_busy = 1'b0;
   logic       ctl_hold = 1'b0;
   int         ctl_frame = 20;
   int         frame_cnt = 0;
   logic       prev_trig = 1'b0;
   int         trig_count = 0;

   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] exp_q[$];

   assign io_ready = auto_ready & ~ctl_hold;

   always #5 clk = ~clk;

   io_tx_byte_queue #(.DEPTH(16), .DATA_W(8)) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .wr_valid                (wr_valid),
      .wr_data                 (wr_data),
      .wr_ready                (wr_ready),
      .level                   (level),
      .overflow                (overflow),
      .overflow_clr            (overflow_clr),
      .io_output_value         (io_output_value),
      .io_output_trigger       (io_output_trigger),
      .io_output_ready_trigger (io_ready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void push_exp(input logic [7:0] b);
`ifdef IO_TX_BYTE_QUEUE_CRLF_EN
      if (b == 8'h0A) exp_q.push_back(8'h0D);
`endif
      exp_q.push_back(b);
   endfunction

   // Controller model: ready drops the cycle after a trigger, returns after ctl_frame cycles.
   always @(negedge clk) begin
      if (rst_n && io_output_trigger) begin
         check("trig_while_ready", 32'(io_ready), 32'd1);
         check("trig_width", 32'(prev_trig), 32'd0);
         check("issue_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            check("issue_value", 32'(io_output_value), 32'(exp_q.pop_front()));
         end
         $display("issue byte %02h (level %0d)", io_output_value, level);
         trig_count++;
         auto_busy  = 1'b1;
         auto_ready = 1'b0;
         frame_cnt  = ctl_frame;
      end else if (auto_busy) begin
         if (frame_cnt == 0) begin
            auto_busy  = 1'b0;
            auto_ready = 1'b1;
         end else begin
            frame_cnt--;
         end
      end
      prev_trig = io_output_trigger;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] b, input bit accept);
      wr_data  = b;
      wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      if (accept) push_exp(b);
   endtask

   task automatic wait_drain(input int max_cycles);
      int n = 0;
      while (exp_q.size() != 0 && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      check("drain_left", 32'(exp_q.size()), 32'd0);
      repeat (ctl_frame + 4) @(negedge clk);
      check("drained_level", 32'(level), 32'd0);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_level", 32'(level), 32'd0);
      check("rst_wr_ready", 32'(wr_ready), 32'd1);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_trigger", 32'(io_output_trigger), 32'd0);
      check("rst_value", 32'(io_output_value), 32'd0);
      rst_n = 1'b1;
      tick();

      // Single byte latency: write edge, then issue edge
      write_byte(8'h41, 1'b1);
      @(posedge clk);
      @(negedge clk);
      check("lat_trigger", 32'(io_output_trigger), 32'd1);
      check("lat_value", 32'(io_output_value), 32'h41);
      check("lat_level", 32'(level), 32'd0);
      #1;
      wait_drain(200);

      // Fill to DEPTH with the controller held busy
      tick();
      ctl_hold = 1'b1;
      for (int i = 1; i <= 16; i++) write_byte(8'(i), 1'b1);
      @(negedge clk);
      check("full_level", 32'(level), 32'd16);
      check("full_wr_ready", 32'(wr_ready), 32'd0);
      check("ovf_before", 32'(overflow), 32'd0);
      tick();
      write_byte(8'hEE, 1'b0);
      @(negedge clk);
      check("ovf_set", 32'(overflow), 32'd1);
      check("ovf_level", 32'(level), 32'd16);
      tick();
      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;
      @(negedge clk);
      check("ovf_clr", 32'(overflow), 32'd0);
      tick();
      // Clear wins over a same-cycle overflow
      overflow_clr = 1'b1;
      write_byte(8'hEF, 1'b0);
      overflow_clr = 1'b0;
      @(negedge clk);
      check("ovf_clr_priority", 32'(overflow), 32'd0);
      #1;
      ctl_hold = 1'b0;
      wait_drain(2000);

      // 20-cycle frames: one trigger per frame, checked by the model
      t0 = trig_count;
      for (int i = 0; i < 4; i++) write_byte(8'h30 + 8'(i), 1'b1);
      wait_drain(400);
      check("frame_triggers", 32'(trig_count - t0), 32'd4);

      // Simultaneous write and pop at level 3
      ctl_frame = 2;
      ctl_hold  = 1'b1;
      write_byte(8'h61, 1'b1);
      write_byte(8'h62, 1'b1);
      write_byte(8'h63, 1'b1);
      @(negedge clk);
      check("sim_level_pre", 32'(level), 32'd3);
      tick();
      ctl_hold = 1'b0;
      write_byte(8'h64, 1'b1);
      @(negedge clk);
      check("sim_level_post", 32'(level), 32'd3);
      check("sim_trigger", 32'(io_output_trigger), 32'd1);
      #1;
      wait_drain(300);

      // Wrap-around: 40 bytes in bursts, order checked by the scoreboard
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 10; i++) write_byte(8'h80 + 8'(b * 10 + i), 1'b1);
         wait_drain(300);
      end

      // Reset while waiting for the controller frame to finish
      ctl_frame = 20;
      ctl_hold  = 1'b1;
      for (int i = 0; i < 6; i++) write_byte(8'hA0 + 8'(i), 1'b1);
      ctl_hold = 1'b0;
      repeat (5) @(negedge clk);
      check("midframe_level", 32'(level), 32'd5);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("mrst_level", 32'(level), 32'd0);
      check("mrst_trigger", 32'(io_output_trigger), 32'd0);
      check("mrst_wr_ready", 32'(wr_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      t0 = trig_count;
      repeat (30) @(negedge clk);
      check("mrst_no_issue", 32'(trig_count), 32'(t0));
      check("mrst_level_idle", 32'(level), 32'd0);
      #1;
      write_byte(8'h55, 1'b1);
      wait_drain(200);
      check("mrst_new_issue", 32'(trig_count - t0), 32'd1);

      // LF handling (CR inserted only when the CRLF option is built in)
      t0 = trig_count;
      write_byte(8'h48, 1'b1);
      write_byte(8'h0A, 1'b1);
      wait_drain(400);
`ifdef IO_TX_BYTE_QUEUE_CRLF_EN
      check("crlf_count", 32'(trig_count - t0), 32'd3);
`else
      check("crlf_count", 32'(trig_count - t0), 32'd2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
